// File: rtl/game_pkg.sv
// game_pkg: constants shared by the game-flow blocks.
//   state_t  - 3-bit game state carried on the game_state bus.
//              WELCOME=0, START=1, PLAY=2, PAUSE=3, FINISH=4.
//              Encodings 5..7 are unused.
// player_move and the renderer import these names so that every consumer
// decodes game_state the same way.
package game_pkg;

    typedef enum logic [2:0] {
        WELCOME = 3'd0,
        START   = 3'd1,
        PLAY    = 3'd2,
        PAUSE   = 3'd3,
        FINISH  = 3'd4
    } state_t;

    localparam int STATE_W = 3;

endpackage

// File: rtl/frame_timer.sv
// frame_timer: turns vsync into a frame tick and counts frames within a
// game second.
//   clk, reset  - system clock, synchronous active-high reset
//   vsync       - active-low vsync pulse, synchronous to clk
//   run         - frame counter advances on frame ticks while high
//   clear       - zeroes the frame counter (wins over run)
//   frame_tick  - registered one-cycle pulse per vsync falling edge
//   sec_tick    - frame_tick on the last frame of a second
module frame_timer #(
    parameter int FRAMES_PER_SEC = 60
) (
    input  logic clk,
    input  logic reset,
    input  logic vsync,
    input  logic run,
    input  logic clear,
    output logic frame_tick,
    output logic sec_tick
);

    localparam int            CW   = $clog2(FRAMES_PER_SEC);
    localparam logic [CW-1:0] LAST = CW'(FRAMES_PER_SEC - 1);

    logic          vsync_q,      vsync_d;
    logic          frame_tick_q, frame_tick_d;
    logic [CW-1:0] count_q,      count_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        vsync_d      = vsync;
        frame_tick_d = vsync_q & ~vsync;
        count_d      = count_q;
        if (clear) begin
            count_d = '0;
        end else if (run && frame_tick_q) begin
            count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
        end
    end

    // vsync history resets high so a vsync held low through reset is not
    // mistaken for a fresh falling edge.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            vsync_q      <= 1'b1;
            frame_tick_q <= 1'b0;
            count_q      <= '0;
        end else begin
            vsync_q      <= vsync_d;
            frame_tick_q <= frame_tick_d;
            count_q      <= count_d;
        end
    end

    assign frame_tick = frame_tick_q;
    assign sec_tick   = frame_tick_q & (count_q == LAST);

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: game-flow controller.
// Steps WELCOME -> START countdown -> PLAY <-> PAUSE -> FINISH -> WELCOME
// and keeps the round clock.
//   clk, reset  - system clock, synchronous active-high reset
//   vsync       - active-low vsync pulse
//   start_btn   - debounced start button (level)
//   pause_btn   - debounced pause button (level)
//   game_state  - current state (game_pkg::state_t encoding)
//   frame_tick  - one-cycle pulse per vsync falling edge
//   countdown   - seconds left in START, 0 elsewhere
//   time_left   - round seconds remaining
//   round_done  - one-cycle pulse in the first FINISH cycle
module game_sequencer
    import game_pkg::*;
#(
    parameter int FRAMES_PER_SEC = 60,
    parameter int START_SECONDS  = 3,
    parameter int GAME_SECONDS   = 180
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       start_btn,
    input  logic       pause_btn,
    output logic [2:0] game_state,
    output logic       frame_tick,
    output logic [1:0] countdown,
    output logic [7:0] time_left,
    output logic       round_done
);

    localparam logic [1:0] START_LOAD = 2'(START_SECONDS);
    localparam logic [7:0] GAME_LOAD  = 8'(GAME_SECONDS);

    state_t     state_q,      state_d;
    logic [1:0] countdown_q,  countdown_d;
    logic [7:0] time_left_q,  time_left_d;
    logic       round_done_q, round_done_d;
    logic       start_q,      pause_q;
    logic       start_rise,   pause_rise;
    logic       sec_tick,     run,         clear;

    assign start_rise = start_btn & ~start_q;
    assign pause_rise = pause_btn & ~pause_q;

    // Frames only count toward a second while the clock is live; any state
    // change restarts the second, so a resumed pause gets a full second.
    assign run   = (state_q == START) || (state_q == PLAY);
    assign clear = (state_d != state_q);

    frame_timer #(
        .FRAMES_PER_SEC(FRAMES_PER_SEC)
    ) u_frame_timer (
        .clk       (clk),
        .reset     (reset),
        .vsync     (vsync),
        .run       (run),
        .clear     (clear),
        .frame_tick(frame_tick),
        .sec_tick  (sec_tick)
    );

    always_comb begin
        state_d      = state_q;
        countdown_d  = countdown_q;
        time_left_d  = time_left_q;
        round_done_d = 1'b0;
        case (state_q)
            WELCOME: begin
                if (start_rise) begin
                    state_d     = START;
                    countdown_d = START_LOAD;
                    time_left_d = GAME_LOAD;
                end
            end
            START: begin
                if (sec_tick) begin
                    countdown_d = countdown_q - 2'd1;
                    if (countdown_q == 2'd1) begin
                        state_d = PLAY;
                    end
                end
            end
            PLAY: begin
                if (sec_tick) begin
                    time_left_d = time_left_q - 8'd1;
                end
                // Running out of time beats a pause press on the same edge.
                if (sec_tick && (time_left_q == 8'd1)) begin
                    state_d      = FINISH;
                    round_done_d = 1'b1;
                end else if (pause_rise) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (pause_rise) begin
                    state_d = PLAY;
                end
            end
            FINISH: begin
                if (start_rise) begin
                    state_d     = WELCOME;
                    time_left_d = GAME_LOAD;
                end
            end
            default: begin
                state_d     = WELCOME;
                countdown_d = 2'd0;
            end
        endcase
    end

    // Button history resets high so a button held through reset gives no edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= WELCOME;
            countdown_q  <= 2'd0;
            time_left_q  <= GAME_LOAD;
            round_done_q <= 1'b0;
            start_q      <= 1'b1;
            pause_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            countdown_q  <= countdown_d;
            time_left_q  <= time_left_d;
            round_done_q <= round_done_d;
            start_q      <= start_btn;
            pause_q      <= pause_btn;
        end
    end

    assign game_state = state_q;
    assign countdown  = countdown_q;
    assign time_left  = time_left_q;
    assign round_done = round_done_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed bench for game_sequencer with a per-cycle
// reference model and hand-computed checkpoints.
module tb_game_sequencer;

    localparam int FPS = 4;
    localparam int SS  = 3;
    localparam int GS  = 5;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       vsync     = 1'b1;
    logic       start_btn = 1'b1;
    logic       pause_btn = 1'b0;
    logic [2:0] game_state;
    logic       frame_tick;
    logic [1:0] countdown;
    logic [7:0] time_left;
    logic       round_done;

    game_sequencer #(
        .FRAMES_PER_SEC(FPS),
        .START_SECONDS (SS),
        .GAME_SECONDS  (GS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .vsync     (vsync),
        .start_btn (start_btn),
        .pause_btn (pause_btn),
        .game_state(game_state),
        .frame_tick(frame_tick),
        .countdown (countdown),
        .time_left (time_left),
        .round_done(round_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 0;

    // Reference model: game phase, seconds left and frames seen in the
    // current second, advanced once per clock from the sampled inputs.
    int m_state  = 0;
    int m_cd     = 0;
    int m_tl     = GS;
    int m_frames = 0;
    bit m_tick   = 0;
    bit m_done   = 0;
    bit m_vs_prev = 1;
    bit m_st_prev = 1;
    bit m_pa_prev = 1;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic model_step();
        int  ns;
        bit  srise, prise, live, second_done;
        if (reset) begin
            m_state = 0; m_cd = 0; m_tl = GS; m_frames = 0;
            m_tick = 0; m_done = 0;
            m_vs_prev = 1; m_st_prev = 1; m_pa_prev = 1;
        end else begin
            srise       = start_btn && !m_st_prev;
            prise       = pause_btn && !m_pa_prev;
            live        = (m_state == 1) || (m_state == 2);
            second_done = live && m_tick && (m_frames + 1 == FPS);
            ns          = m_state;
            m_done      = 0;
            case (m_state)
                0: if (srise) begin ns = 1; m_cd = SS; m_tl = GS; end
                1: if (second_done) begin
                       m_cd = m_cd - 1;
                       if (m_cd == 0) ns = 2;
                   end
                2: begin
                       if (second_done) m_tl = m_tl - 1;
                       if (second_done && m_tl == 0) begin ns = 4; m_done = 1; end
                       else if (prise) ns = 3;
                   end
                3: if (prise) ns = 2;
                4: if (srise) begin ns = 0; m_tl = GS; end
                default: ns = 0;
            endcase
            if (ns != m_state) m_frames = 0;
            else if (live && m_tick) m_frames = second_done ? 0 : m_frames + 1;
            m_state   = ns;
            m_tick    = m_vs_prev && !vsync;
            m_vs_prev = vsync;
            m_st_prev = start_btn;
            m_pa_prev = pause_btn;
        end
    endtask

    // Advance one clock; inputs change 1 ns after the edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            #1;
        end
    endtask

    // One frame: vsync low for a cycle, then high for two.
    task automatic frames(input int n);
        repeat (n) begin
            vsync = 1'b0;
            cyc(1);
            vsync = 1'b1;
            cyc(2);
        end
    endtask

    task automatic press_start();
        start_btn = 1'b0;
        cyc(1);
        start_btn = 1'b1;
        cyc(1);
    endtask

    task automatic press_pause();
        pause_btn = 1'b1;
        cyc(1);
        pause_btn = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                check("model game_state", int'(game_state), m_state);
                check("model countdown",  int'(countdown),  m_cd);
                check("model time_left",  int'(time_left),  m_tl);
                check("model frame_tick", int'(frame_tick), int'(m_tick));
                check("model round_done", int'(round_done), int'(m_done));
            end
        end
    end

    initial begin
        // Reset with start held high; holding it afterwards is not an edge.
        cyc(1);
        check_en = 1;
        cyc(1);
        reset = 1'b0;
        check("reset game_state", int'(game_state), 0);
        check("reset time_left",  int'(time_left),  5);
        check("reset countdown",  int'(countdown),  0);
        check("reset frame_tick", int'(frame_tick), 0);
        check("reset round_done", int'(round_done), 0);
        frames(10);
        check("held start state", int'(game_state), 0);
        check("held start time",  int'(time_left),  5);

        // Countdown: 3 -> 2 -> 1 -> PLAY, one second per 4 frames.
        press_start();
        check("start state", int'(game_state), 1);
        check("start cd",    int'(countdown),  3);
        frames(4);
        check("cd after 4",  int'(countdown),  2);
        frames(4);
        check("cd after 8",  int'(countdown),  1);
        frames(4);
        check("cd after 12", int'(countdown),  0);
        check("play entry",  int'(game_state), 2);
        check("play time",   int'(time_left),  5);

        // Pause 2 frames into a second; resume with a fresh second.
        frames(2);
        press_pause();
        check("paused state", int'(game_state), 3);
        frames(10);
        check("paused time",  int'(time_left),  5);
        press_pause();
        check("resumed state", int'(game_state), 2);
        frames(3);
        check("resume 3 ticks", int'(time_left), 5);
        frames(1);
        check("resume 4 ticks", int'(time_left), 4);
        frames(12);
        check("time at 1", int'(time_left), 1);
        frames(3);
        check("time still 1", int'(time_left), 1);

        // Last second expires on the same edge as a pause press.
        vsync = 1'b0;
        cyc(1);
        vsync = 1'b1;
        pause_btn = 1'b1;
        cyc(1);
        check("race state",      int'(game_state), 4);
        check("race time",       int'(time_left),  0);
        check("race round_done", int'(round_done), 1);
        cyc(1);
        check("round_done drop", int'(round_done), 0);
        check("finish holds",    int'(game_state), 4);
        pause_btn = 1'b0;
        cyc(1);

        // FINISH -> WELCOME reloads the clock.
        press_start();
        check("finish exit state", int'(game_state), 0);
        check("finish exit time",  int'(time_left),  5);

        // Full round without pause: 20 ticks of PLAY.
        press_start();
        frames(12);
        check("round2 play", int'(game_state), 2);
        for (int i = 1; i <= 5; i++) begin
            frames(4);
            check("round2 time", int'(time_left), 5 - i);
            check("round2 state", int'(game_state), (i == 5) ? 4 : 2);
        end

        // Reset in the middle of PLAY discards the round.
        press_start();
        press_start();
        frames(12);
        frames(12);
        check("mid play time", int'(time_left), 2);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("mid reset state", int'(game_state), 0);
        check("mid reset time",  int'(time_left),  5);
        check("mid reset cd",    int'(countdown),  0);
        check("mid reset tick",  int'(frame_tick), 0);
        cyc(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level game-flow controller. It produces the `game_state` bus that gates player movement and all other gameplay datapaths. It derives a one-cycle frame tick from `vsync`, steps the game through WELCOME → START countdown → PLAY ↔ PAUSE → FINISH, and owns the round clock shown on the HUD.

## Interface
- `FRAMES_PER_SEC`, 60: frames per game second; range 2..255.
- `START_SECONDS`, 3: pre-play countdown length; range 1..3.
- `GAME_SECONDS`, 180: round length; range 1..255.
- `clk`  in  1: system clock; all state is updated on its rising edge.
- `reset`  in  1: reset, synchronous, active-high.
- `vsync`  in  1: video vsync, active-low pulse, synchronous to `clk`.
- `start_btn`  in  1: debounced start button, level.
- `pause_btn`  in  1: debounced pause button, level.
- `game_state`  out  3: WELCOME=0, START=1, PLAY=2, PAUSE=3, FINISH=4.
- `frame_tick`  out  1: one-cycle pulse per vsync falling edge.
- `countdown`  out  2: seconds remaining in START; 0 in all other states.
- `time_left`  out  8: round seconds remaining.
- `round_done`  out  1: one-cycle pulse on entry to FINISH.

## Operation
- Reset values:
  - `game_state` = WELCOME.
  - `frame_tick` = 0.
  - `countdown` = 0.
  - `time_left` = GAME_SECONDS.
  - `round_done` = 0.
  - Internal frame counter = 0.
  - `vsync_q` = 1.
  - Button history registers = 1, so a button already held through reset produces no edge.
- Edge detection:
  - `start_rise` = `start_btn` & ~`start_q`.
  - `pause_rise` = `pause_btn` & ~`pause_q`.
  - `frame_tick` is registered: set to `vsync_q` & ~`vsync`.
- Frame counter: counts 0..FRAMES_PER_SEC-1 on `frame_tick`, but only in START and PLAY.
  - It holds its value in PAUSE.
  - It is cleared on every state transition.
  - `sec_tick` = `frame_tick` & (count == FRAMES_PER_SEC-1).
- FSM, priority top-down within each state:
  - WELCOME: on `start_rise`, go to START. Load `countdown` = START_SECONDS and `time_left` = GAME_SECONDS.
  - START: on `sec_tick`, decrement `countdown`. When `countdown`==1 and `sec_tick`, set `countdown` = 0 and go to PLAY. Buttons are ignored.
  - PLAY: on `sec_tick`, decrement `time_left`.
    - If `time_left`==1 and `sec_tick`, set `time_left` = 0, go to FINISH, and pulse `round_done`. This wins over a simultaneous `pause_rise`.
    - Else, on `pause_rise`, go to PAUSE.
  - PAUSE: on `pause_rise`, go to PLAY with the frame counter cleared. `time_left` is frozen. `start_btn` is ignored.
  - FINISH: `time_left` holds 0. On `start_rise`, go to WELCOME and reload `time_left` = GAME_SECONDS.
- `time_left` never wraps. It only decrements in PLAY, and at 0 the FSM has already left PLAY.
- Encodings 5..7 are unreachable. If entered, the next cycle goes to WELCOME.
- Reset asserted in any state returns to WELCOME on the next edge. An in-progress round is discarded.

## Timing
- `frame_tick` rises on the first `clk` edge at which `vsync` is sampled low after being high. It lasts exactly 1 cycle.
- State, `countdown` and `time_left` update on the same edge that samples the qualifying pulse (`start_rise`, `pause_rise` or `sec_tick`). Latency is 1 cycle from the button edge.
- `round_done` is high in the first cycle `game_state`==FINISH.
- Consumers that update per frame see the new `game_state` before the next `frame_tick`.
- Both START and PLAY clear the frame counter on entry. START therefore lasts START_SECONDS×FRAMES_PER_SEC frame ticks, and PLAY lasts GAME_SECONDS×FRAMES_PER_SEC ticks excluding paused frames.
- A pause taken mid-second resumes with a full fresh second. This rounding is intended.

## Structure
- Shared package `game_pkg`:
  - State localparams WELCOME..FINISH.
  - `state_t`, a 3-bit type.
  - `player_move` and the renderer import these constants instead of redefining them.
- One sub-module, `frame_timer`:
  - Performs vsync edge detection and the frame counter.
  - Inputs: `clk`, `reset`, `vsync`, `run`, `clear`.
  - Outputs: `frame_tick`, `sec_tick`.
- The FSM, button edge detectors and second counters stay in `game_sequencer`.

## Test plan
Use FRAMES_PER_SEC=4, START_SECONDS=3, GAME_SECONDS=5 throughout.
- Reset with `start_btn` held high, then hold it 10 frames: `game_state` stays 0, `time_left`=5.
- `start_rise`: next cycle `game_state`=1, `countdown`=3. After 4, 8 and 12 frame ticks, `countdown` reads 2, 1, then 0 with `game_state`=2.
- PLAY, 20 frame ticks:
  - `time_left` steps 4,3,2,1,0.
  - `game_state`=4 on the 20th tick.
  - `round_done` is high exactly 1 cycle.
- PLAY, `pause_rise` after 2 ticks into a second:
  - `game_state`=3; 10 frame ticks leave `time_left` unchanged.
  - A second `pause_rise` returns `game_state` to 2; the next decrement comes after 4 ticks.
- PLAY with `time_left`=1 and counter at 3: `pause_rise` coincident with `frame_tick` → `game_state`=4, not 3.
- Reset mid-PLAY (`time_left`=2) → `game_state`=0, `time_left`=5, `countdown`=0, `frame_tick`=0. In FINISH, `start_rise` → WELCOME with `time_left`=5.
